// File: rtl/led_scanner.sv
// led_scanner: bounce / wrap / fill LED animator.
// Steps on an internal prescaler tick; every register runs on clk.
module led_scanner #(
  parameter int LED_COUNT = 4,
  parameter int TICK_DIV = 0,
  localparam int POS_W = (LED_COUNT > 2) ? $clog2(LED_COUNT) : 1,
  localparam int CNT_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn,
  input  logic [1:0]           mode,
  output logic [LED_COUNT-1:0] leds,
  output logic [POS_W-1:0]     pos,
  output logic                 dir,
  output logic                 active,
  output logic                 wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [POS_W-1:0] LAST    = POS_W'(LED_COUNT - 1);
  localparam logic [POS_W-1:0] ONE     = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic                 tick;
  logic                 bad_pos;
  logic [LED_COUNT-1:0] leds_n;
  logic [POS_W-1:0]     pos_n;
  logic                 dir_n;
  logic                 wrap_n;

  function automatic logic [LED_COUNT-1:0] onehot(input logic [POS_W-1:0] p);
    logic [LED_COUNT-1:0] r;
    for (int i = 0; i < LED_COUNT; i++) r[i] = (POS_W'(i) == p);
    return r;
  endfunction

  function automatic logic [LED_COUNT-1:0] fillmask(input logic [POS_W-1:0] p);
    logic [LED_COUNT-1:0] r;
    for (int i = 0; i < LED_COUNT; i++) r[i] = (POS_W'(i) <= p);
    return r;
  endfunction

  // pause suppresses the tick entirely, so the pattern freezes
  assign tick    = btn && (mode != 2'b11) && (cnt == CNT_TOP);
  assign bad_pos = (int'(pos) >= LED_COUNT);
  assign active  = (state == RUN);

  // step prescaler; restarts from zero after idle, pause or a step
  always_ff @(posedge clk) begin
    if (rst || !btn || mode == 2'b11 || tick) cnt <= '0;
    else cnt <= cnt + CNT_W'(1);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      leds  <= '0;
      pos   <= '0;
      dir   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      leds  <= leds_n;
      pos   <= pos_n;
      dir   <= dir_n;
      wrap  <= wrap_n;
    end
  end

  // next pattern step, evaluated only on a tick
  always_comb begin
    state_n = state;
    leds_n  = leds;
    pos_n   = pos;
    dir_n   = dir;
    wrap_n  = 1'b0;
    if (!btn) begin
      state_n = IDLE;
      leds_n  = '0;
      pos_n   = '0;
      dir_n   = 1'b0;
    end else if (tick) begin
      if (state == IDLE) begin
        state_n = RUN;
        pos_n   = '0;
        dir_n   = 1'b0;
        leds_n  = onehot('0);
      end else if (bad_pos) begin
        state_n = IDLE;
        leds_n  = '0;
        pos_n   = '0;
        dir_n   = 1'b0;
      end else begin
        unique case (mode)
          2'b00: begin
            if (!dir) begin
              if (pos < LAST) begin
                pos_n = pos + ONE;
              end else begin
                pos_n = pos - ONE;
                dir_n = 1'b1;
              end
            end else begin
              if (pos != '0) begin
                pos_n = pos - ONE;
              end else begin
                pos_n  = ONE;
                dir_n  = 1'b0;
                wrap_n = 1'b1;
              end
            end
            leds_n = onehot(pos_n);
          end
          2'b01: begin
            dir_n = 1'b0;
            if (pos == LAST) begin
              pos_n  = '0;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos + ONE;
            end
            leds_n = onehot(pos_n);
          end
          2'b10: begin
            dir_n = 1'b0;
            if (pos < LAST) begin
              pos_n  = pos + ONE;
              leds_n = fillmask(pos_n);
            end else begin
              state_n = IDLE;
              pos_n   = '0;
              leds_n  = '0;
              wrap_n  = 1'b1;
            end
          end
          default: begin
            state_n = state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed checks of led_scanner
// two instances: 4 LEDs / div 0 and 8 LEDs / div 2
module tb_led_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b1;
  logic [1:0] mode = 2'b00;

  logic [3:0] leds4;
  logic [1:0] pos4;
  logic       dir4, act4, wrap4;
  logic [7:0] leds8;
  logic [2:0] pos8;
  logic       dir8, act8, wrap8;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_scanner #(.LED_COUNT(4), .TICK_DIV(0)) u4 (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode),
    .leds(leds4), .pos(pos4), .dir(dir4),
    .active(act4), .wrap(wrap4)
  );

  led_scanner #(.LED_COUNT(8), .TICK_DIV(2)) u8 (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode),
    .leds(leds8), .pos(pos8), .dir(dir8),
    .active(act8), .wrap(wrap8)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] b_led [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                            4'b0010, 4'b0001, 4'b0010};
  logic [1:0] b_pos [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
  logic       b_dir [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       b_wrp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [3:0] f_led [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                            4'b0000, 4'b0001};
  logic       f_act [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       f_wrp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int pulses;
    int f;
    logic [7:0] exp8;

    // reset held with btn high
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_leds", 32'(leds4), 32'd0);
      check("rst_pos", 32'(pos4), 32'd0);
      check("rst_dir", 32'(dir4), 32'd0);
      check("rst_act", 32'(act4), 32'd0);
      check("rst_wrap", 32'(wrap4), 32'd0);
    end
    rst = 1'b0;
    step();
    check("first_leds", 32'(leds4), 32'd1);
    check("first_act", 32'(act4), 32'd1);

    // bounce on 4 LEDs
    for (int i = 0; i < 7; i++) begin
      step();
      check("bnc_leds", 32'(leds4), 32'(b_led[i]));
      check("bnc_pos", 32'(pos4), 32'(b_pos[i]));
      check("bnc_dir", 32'(dir4), 32'(b_dir[i]));
      check("bnc_wrap", 32'(wrap4), 32'(b_wrp[i]));
    end

    // wrap chase on 8 LEDs, step every 3 cycles
    rst = 1'b1;
    mode = 2'b01;
    step();
    rst = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 30; e++) begin
      step();
      f = e / 3;
      exp8 = (f == 0) ? 8'h00 : (8'h01 << ((f - 1) % 8));
      check("wrp_leds", 32'(leds8), 32'(exp8));
      check("wrp_wrap", 32'(wrap8), 32'(e == 27));
      if (wrap8) pulses++;
    end
    check("wrp_pulses", 32'(pulses), 32'd1);

    // fill on 4 LEDs
    rst = 1'b1;
    mode = 2'b10;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("fil_leds", 32'(leds4), 32'(f_led[i]));
      check("fil_act", 32'(act4), 32'(f_act[i]));
      check("fil_wrap", 32'(wrap4), 32'(f_wrp[i]));
    end

    // pause then switch to wrap on 8 LEDs
    rst = 1'b1;
    mode = 2'b00;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("pse_start", 32'(leds8), 32'h04);
    check("pse_dir", 32'(dir8), 32'd0);
    mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      step();
      check("pse_hold", 32'(leds8), 32'h04);
    end
    mode = 2'b01;
    step();
    check("pse_res1", 32'(leds8), 32'h04);
    step();
    check("pse_res2", 32'(leds8), 32'h04);
    step();
    check("pse_res3", 32'(leds8), 32'h08);

    // abort on 4 LEDs at 1000
    rst = 1'b1;
    mode = 2'b00;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abt_pre", 32'(leds4), 32'h8);
    btn = 1'b0;
    step();
    check("abt_leds", 32'(leds4), 32'd0);
    check("abt_pos", 32'(pos4), 32'd0);
    check("abt_act", 32'(act4), 32'd0);
    btn = 1'b1;
    step();
    check("abt_rest", 32'(leds4), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
# led_scanner

Parametrised LED pattern generator driving a bank of `LED_COUNT` board LEDs.
- Three animation modes plus pause: bounce ("Zylon" scan), wrap-around chase and fill ("rain meter").
- Advances on an internal step prescaler, so no derived clock is created; all logic runs on `clk`.
- Sits between the board button/switch debouncers and the LED pins in the tutorial top level.

## Interface
Parameters:
- `LED_COUNT`, 4, number of LEDs; legal range 2..32.
- `TICK_DIV`, 0, step period is `TICK_DIV+1` clk cycles; legal range 0..2^24-1.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn`  in  1  run enable, level-sensitive and already debounced; low forces blank/idle.
- `mode`  in  2  00 bounce, 01 wrap, 10 fill, 11 pause.
- `leds`  out  LED_COUNT  registered LED pattern; bit 0 is the rightmost LED.
- `pos`  out  POS_W  registered current position; POS_W = max(1, clog2(LED_COUNT)).
- `dir`  out  1  registered direction; 0 is up (toward MSB), 1 is down.
- `active`  out  1  registered; 1 while in RUN.
- `wrap`  out  1  one-cycle pulse at the end of each full pattern cycle.

## Operation
Internal counter `cnt`:
- Width max(1, clog2(TICK_DIV+1)).
- `tick = btn && (cnt == TICK_DIV)`.
- On `tick`, `cnt` returns to 0; otherwise it increments while `btn` is 1.
- `cnt` is held at 0 while `btn` is 0 or `mode` is 11.

Reset or `btn` = 0 at an edge (`rst` has priority; identical result):
- state IDLE, `leds` = 0, `pos` = 0, `dir` = 0, `active` = 0, `wrap` = 0, `cnt` = 0.

IDLE, on `tick` (mode not 11):
- Go to RUN with `pos` = 0, `dir` = 0, `leds` = 1 in all modes.

RUN, on `tick`, evaluated with the `mode` value sampled at that edge:
- Bounce (00), up:
  - `pos` < LED_COUNT-1: `pos` + 1.
  - `pos` = LED_COUNT-1: `pos` - 1 and `dir` ← 1.
- Bounce (00), down:
  - `pos` > 0: `pos` - 1.
  - `pos` = 0: `pos` ← 1, `dir` ← 0, and pulse `wrap`.
- Bounce pattern: `leds` = one-hot(`pos`). End LEDs are lit for one step only, e.g. 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
- Wrap (01): `pos` ← (`pos`+1) mod LED_COUNT, `dir` ← 0, `leds` = one-hot. `wrap` pulses when `pos` goes LED_COUNT-1 → 0.
- Fill (10): `leds` = bits 0..`pos` set, `dir` ← 0.
  - `pos` < LED_COUNT-1: `pos` + 1.
  - `pos` = LED_COUNT-1: go to IDLE (`leds` = 0, `pos` = 0, `active` = 0) and pulse `wrap`.
  - The next `tick` restarts the pattern, giving LED_COUNT+1 frames per cycle.
- Pause (11): no `tick` is generated. `leds`, `pos`, `dir` and state are held.

Mode change in RUN:
- Takes effect at the next `tick`; `pos` is kept.
- Entering fill recomputes `leds` as a mask at that tick.
- Entering bounce from another mode starts with `dir` = 0.

A `pos` value out of range (unreachable) → IDLE on the next tick.

## Timing
- All outputs are registered. `leds`, `pos`, `dir` and `active` change only on a `tick` edge, or on the first edge at which `rst` or `btn` = 0 is sampled.
- Latency from `btn` sampled high at edge k (from IDLE) to first `leds` = 1: edge k+TICK_DIV.
- `btn` falling: `leds` = 0 after the first edge where it is sampled low. This holds mid-pattern, even if `tick` is coincident.
- `wrap` is high for exactly one clk cycle, in the cycle after its tick edge, and is 0 in all other cycles.
- Step rate: exactly one pattern step per `TICK_DIV+1` cycles while running and not paused.
- Resume after pause: counting restarts from `cnt` = 0, so the next step comes `TICK_DIV+1` cycles after `mode` leaves 11.

## Test plan
- Reset: `rst` = 1 for 3 cycles with `btn` = 1 and mode 00 → `leds` = 0, `pos` = 0, `dir` = 0, `active` = 0, `wrap` = 0 during and one edge after; then `leds` = 0001 at the first `tick`.
- Bounce, LED_COUNT = 4, TICK_DIV = 0: `btn` held high → `leds` sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 on consecutive edges; `dir` flips at 1000 and 0001; `wrap` pulses once per 6 steps.
- Wrap, LED_COUNT = 8, TICK_DIV = 2: `btn` high for 30 cycles → `leds` steps every 3 cycles, 0x01 … 0x80, 0x01; `wrap` pulses exactly once, in the cycle after the 0x80 → 0x01 edge.
- Fill, LED_COUNT = 4, TICK_DIV = 0 → `leds` 0001, 0011, 0111, 1111, 0000, 0001; `active` = 0 on the 0000 frame; `wrap` pulses once on the transition into 0000.
- Pause and mode change: bounce at `leds` = 0100 going up, `mode` = 11 for 10 cycles → `leds` held at 0100; `mode` = 01 → next step 1000 after `TICK_DIV+1` cycles.
- Abort: `btn` dropped at `leds` = 1000 coincident with a `tick` → `leds` = 0 and `pos` = 0 next edge; `btn` re-raised → pattern restarts at 0001 after `TICK_DIV+1` edges.
